// File: rtl/result_unloader.sv
// result_unloader: drains the 3x3 MAC array.
// On a rising edge of unload_res the nine accumulators and the result
// dimensions are snapshotted. The valid row_w x col_x elements are then
// streamed out in row-major order over a valid/ready handshake, and a
// one-cycle done pulse follows the last transfer.
// Optional build macro: RESULT_UNLOADER_LAST_EN adds a data_last output
// that marks the final element of each stream.
module result_unloader #(
    parameter int RES_W = 10,
    parameter int MAC_N = 9
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   unload_res,
    input  logic [MAC_N*RES_W-1:0] mac_res,
    input  logic [1:0]             row_w,
    input  logic [1:0]             col_x,
    output logic [RES_W-1:0]       data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   busy,
    output logic                   done
`ifdef RESULT_UNLOADER_LAST_EN
    ,
    output logic                   data_last
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    logic [1:0]       r_state;
    logic             r_unloadPrev;
    logic [RES_W-1:0] r_snap [MAC_N];
    logic [1:0]       r_rows;
    logic [1:0]       r_cols;
    logic [1:0]       r_row;
    logic [1:0]       r_col;

    logic             w_rise;
    logic             w_colLast;
    logic             w_rowLast;
    logic             w_curLast;
    logic [1:0]       w_nextRow;
    logic [1:0]       w_nextCol;
    logic             w_nextLast;
    logic [3:0]       w_curIdx;
    logic [3:0]       w_nextIdx;
    logic [RES_W-1:0] w_curData;
    logic [RES_W-1:0] w_nextData;

    // Selects a snapshot slot; indices past the array read as zero.
    function automatic logic [RES_W-1:0] slotAt(input logic [3:0] idx);
        slotAt = '0;
        for (int k = 0; k < MAC_N; k++) begin
            if (idx == 4'(k)) begin
                slotAt = r_snap[k];
            end
        end
    endfunction

    // Computes 3*row + col in 4 bits; legal dimensions keep this at or below 8.
    function automatic logic [3:0] rowMajor(input logic [1:0] row, input logic [1:0] col);
        rowMajor = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    endfunction

    // Edge detect, current/next position and the element data for each.
    always_comb begin
        w_rise     = unload_res & ~r_unloadPrev;
        w_colLast  = (r_col == (r_cols - 2'd1));
        w_rowLast  = (r_row == (r_rows - 2'd1));
        w_curLast  = w_colLast & w_rowLast;
        w_nextRow  = r_row;
        w_nextCol  = r_col + 2'd1;
        if (w_colLast) begin
            w_nextRow = r_row + 2'd1;
            w_nextCol = 2'd0;
        end
        w_nextLast = (w_nextRow == (r_rows - 2'd1)) && (w_nextCol == (r_cols - 2'd1));
        w_curIdx   = rowMajor(r_row, r_col);
        w_nextIdx  = rowMajor(w_nextRow, w_nextCol);
        w_curData  = slotAt(w_curIdx);
        w_nextData = slotAt(w_nextIdx);
    end

    // Sequencer: snapshot on the unload_res rise, load, stream, then pulse done.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= ST_IDLE;
            r_unloadPrev <= 1'b0;
            r_rows       <= 2'd0;
            r_cols       <= 2'd0;
            r_row        <= 2'd0;
            r_col        <= 2'd0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef RESULT_UNLOADER_LAST_EN
            data_last    <= 1'b0;
`endif
            for (int k = 0; k < MAC_N; k++) begin
                r_snap[k] <= '0;
            end
        end else begin
            r_unloadPrev <= unload_res;
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (w_rise) begin
                        for (int k = 0; k < MAC_N; k++) begin
                            r_snap[k] <= mac_res[k*RES_W +: RES_W];
                        end
                        r_rows <= row_w;
                        r_cols <= col_x;
                        r_row  <= 2'd0;
                        r_col  <= 2'd0;
                        busy   <= 1'b1;
                        if ((row_w == 2'd0) || (col_x == 2'd0)) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    data_out   <= w_curData;
                    data_valid <= 1'b1;
`ifdef RESULT_UNLOADER_LAST_EN
                    data_last  <= w_curLast;
`endif
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (data_valid && data_ready) begin
                        if (w_curLast) begin
                            data_valid <= 1'b0;
`ifdef RESULT_UNLOADER_LAST_EN
                            data_last  <= 1'b0;
`endif
                            r_state    <= ST_FIN;
                        end else begin
                            r_row    <= w_nextRow;
                            r_col    <= w_nextCol;
                            data_out <= w_nextData;
`ifdef RESULT_UNLOADER_LAST_EN
                            data_last <= w_nextLast;
`endif
                        end
                    end
                end
                ST_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef RESULT_UNLOADER_LAST_EN
    // The last-element flag only drives a port when that port is built.
    logic w_unusedLast;
    assign w_unusedLast = w_nextLast;
`endif

endmodule

// File: tb/tb_result_unloader.sv
// tb_result_unloader: scoreboard bench for result_unloader.
// Stimulus pushes expected elements into a queue; a negedge monitor pops
// and compares on every handshake and checks that held data stays stable.
// Build with RESULT_UNLOADER_LAST_EN to also check data_last.
module tb_result_unloader;

    localparam int RES_W = 10;
    localparam int MAC_N = 9;

    logic                   clk = 1'b0;
    logic                   clear_n;
    logic                   unload_res;
    logic [MAC_N*RES_W-1:0] mac_res;
    logic [1:0]             row_w;
    logic [1:0]             col_x;
    logic [RES_W-1:0]       data_out;
    logic                   data_valid;
    logic                   data_ready;
    logic                   busy;
    logic                   done;
`ifdef RESULT_UNLOADER_LAST_EN
    logic                   data_last;
`endif

    int checks = 0;
    int failures = 0;
    int xferCount = 0;
    int doneCount = 0;
    int validCycles = 0;
    logic readyAlt = 1'b0;
    logic [RES_W:0] expQ [$];

    logic             holdPending = 1'b0;
    logic [RES_W-1:0] holdData = '0;

    result_unloader #(.RES_W(RES_W), .MAC_N(MAC_N)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .unload_res (unload_res),
        .mac_res    (mac_res),
        .row_w      (row_w),
        .col_x      (col_x),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done)
`ifdef RESULT_UNLOADER_LAST_EN
        ,
        .data_last  (data_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Ready is tied high or toggled each cycle, changed just after the edge.
    always @(posedge clk) begin
        #1;
        data_ready = readyAlt ? ~data_ready : 1'b1;
    end

    // Monitor: pops the scoreboard on each handshake and checks held data.
    always @(negedge clk) begin
        logic [RES_W:0] expEntry;
        if (!clear_n) begin
            holdPending = 1'b0;
        end else begin
            if (done) doneCount++;
            if (data_valid) validCycles++;
            if (holdPending) begin
                checkOutput("hold_valid", 32'(data_valid), 32'd1);
                checkOutput("hold_data", 32'(data_out), 32'(holdData));
            end
            if (data_valid && data_ready) begin
                xferCount++;
                holdPending = 1'b0;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_element actual=%0d expected=none", data_out);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("element", 32'(data_out), 32'(expEntry[RES_W-1:0]));
`ifdef RESULT_UNLOADER_LAST_EN
                    checkOutput("element_last", 32'(data_last), 32'(expEntry[RES_W]));
`endif
                end
            end else if (data_valid) begin
                holdPending = 1'b1;
                holdData    = data_out;
            end else begin
                holdPending = 1'b0;
            end
        end
    end

    // Queues the expected stream, then makes a clean rise on unload_res.
    // Returns one edge after the first element should be visible.
    task automatic applyStimulus(input int rows, input int cols,
                                 input logic [MAC_N*RES_W-1:0] res, input bit keepHigh);
        @(posedge clk);
        #1;
        unload_res = 1'b0;
        mac_res    = res;
        row_w      = 2'(rows);
        col_x      = 2'(cols);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                expQ.push_back({(r == rows - 1) && (c == cols - 1), res[(3*r + c)*RES_W +: RES_W]});
            end
        end
        @(posedge clk);
        #1;
        unload_res = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_after_rise", 32'(busy), 32'd1);
        checkOutput("valid_after_rise", 32'(data_valid), 32'd0);
        mac_res = {MAC_N*RES_W{1'b1}};
        row_w   = 2'd3;
        col_x   = 2'd3;
        if (!keepHigh) unload_res = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("valid_two_edges", 32'(data_valid), 32'((rows * cols) > 0));
    endtask

    // Waits (bounded) for done, then checks counts and idle outputs.
    task automatic waitStreamEnd(input int expXfers, input int startXfer, input int startDone);
        int i;
        for (i = 0; i < 200; i++) begin
            if (doneCount > startDone) break;
            @(posedge clk);
        end
        if (i == 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=%0d expected=%0d", doneCount - startDone, 1);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("done_pulses", 32'(doneCount - startDone), 32'd1);
        checkOutput("transfers", 32'(xferCount - startXfer), 32'(expXfers));
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("valid_idle", 32'(data_valid), 32'd0);
    endtask

    function automatic logic [MAC_N*RES_W-1:0] makeSlots(input int base, input int step);
        logic [MAC_N*RES_W-1:0] v;
        v = '0;
        for (int k = 0; k < MAC_N; k++) begin
            v[k*RES_W +: RES_W] = RES_W'(base + step * k);
        end
        return v;
    endfunction

    initial begin
        int sx;
        int sd;
        int sv;
        int i;
        clear_n    = 1'b0;
        unload_res = 1'b0;
        mac_res    = '0;
        row_w      = 2'd0;
        col_x      = 2'd0;
        data_ready = 1'b1;

        #2;
        checkOutput("reset_data_out", 32'(data_out), 32'd0);
        checkOutput("reset_valid", 32'(data_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #2;
        clear_n = 1'b1;

        $display("[TB] 3x3 stream, ready tied high");
        sx = xferCount; sd = doneCount;
        applyStimulus(3, 3, makeSlots(100, 1), 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("valid_after_nine", 32'(data_valid), 32'd0);
        checkOutput("done_not_yet", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_timing", 32'(done), 32'd1);
        waitStreamEnd(9, sx, sd);

        $display("[TB] 2x3 stream with back-pressure");
        readyAlt = 1'b1;
        sx = xferCount; sd = doneCount;
        applyStimulus(2, 3, makeSlots(0, 1), 1'b0);
        waitStreamEnd(6, sx, sd);
        readyAlt = 1'b0;

        $display("[TB] 3x2 partial columns");
        sx = xferCount; sd = doneCount;
        applyStimulus(3, 2, makeSlots(1, 10), 1'b0);
        waitStreamEnd(6, sx, sd);

        $display("[TB] zero dimension");
        sx = xferCount; sd = doneCount; sv = validCycles;
        applyStimulus(0, 3, makeSlots(5, 1), 1'b0);
        waitStreamEnd(0, sx, sd);
        checkOutput("zero_dim_valid_cycles", 32'(validCycles - sv), 32'd0);

        $display("[TB] 1x1 stream");
        sx = xferCount; sd = doneCount;
        applyStimulus(1, 1, makeSlots(675, 0), 1'b0);
        checkOutput("single_data", 32'(data_out), 32'd675);
`ifdef RESULT_UNLOADER_LAST_EN
        checkOutput("single_last_high", 32'(data_last), 32'd1);
`endif
        @(posedge clk);
        #1;
        checkOutput("single_valid_clears", 32'(data_valid), 32'd0);
`ifdef RESULT_UNLOADER_LAST_EN
        checkOutput("single_last_clears", 32'(data_last), 32'd0);
`endif
        waitStreamEnd(1, sx, sd);

        $display("[TB] mid-stream reset and restart");
        sx = xferCount; sd = doneCount;
        applyStimulus(3, 3, makeSlots(100, 1), 1'b0);
        for (i = 0; i < 100; i++) begin
            @(posedge clk);
            if (xferCount - sx >= 4) break;
        end
        if (i == 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL reset_wait_timeout actual=%0d expected=%0d", xferCount - sx, 4);
        end
        #2;
        clear_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(data_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_data", 32'(data_out), 32'd0);
        expQ.delete();
        @(posedge clk);
        #2;
        clear_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(doneCount - sd), 32'd0);
        checkOutput("abort_transfers", 32'(xferCount - sx), 32'd4);

        sx = xferCount; sd = doneCount;
        applyStimulus(3, 3, makeSlots(675, 0), 1'b1);
        waitStreamEnd(9, sx, sd);
        sx = xferCount; sd = doneCount; sv = validCycles;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("level_no_restart_xfers", 32'(xferCount - sx), 32'd0);
        checkOutput("level_no_restart_valid", 32'(validCycles - sv), 32'd0);
        checkOutput("level_no_restart_done", 32'(doneCount - sd), 32'd0);
        checkOutput("level_no_restart_busy", 32'(busy), 32'd0);
        unload_res = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Output-side counterpart of the input memory bank.
- The memory bank takes matrix elements serially and deals them into the 3x3 MAC array. This block waits for the bank's unload_res, snapshots the nine MAC accumulators, and streams the valid result elements out serially, one per accepted transfer.
- Elements leave in row-major order over a valid/ready handshake, then a done pulse is issued.

Parameters:
- RES_W, 10, width of each MAC accumulator and of data_out; 10 covers 3 x 15 x 15 = 675.
- MAC_N, 9, number of MAC result slots; fixed 3x3 array, not intended to change.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- unload_res  input  1  from the memory bank; high means multiplication is complete.
- mac_res  input  MAC_N*RES_W  flattened accumulators; slot k = bits [k*RES_W +: RES_W]; k = 3*r + c (m11 = 0 ... m33 = 8).
- row_w  input  2  rows of the result (rows of W).
- col_x  input  2  columns of the result (columns of X).
- data_out  output  RES_W  current result element.
- data_valid  output  1  data_out holds an untransferred element.
- data_ready  input  1  consumer accepts data_out this cycle.
- busy  output  1  snapshot held, stream in progress.
- done  output  1  one-cycle pulse after the final element transfers.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state IDLE.
  - data_out = 0, data_valid = 0, busy = 0, done = 0.
  - row/column counters = 0, snapshot registers = 0, unload_res edge-detect register = 0.
- All outputs are registered.
- States: IDLE, LOAD, SEND, FIN.
- IDLE:
  - Rising-edge detect on unload_res (current = 1, registered previous = 0).
  - At that edge E0: copy all nine mac_res slots into the snapshot, latch row_w and col_x, clear r = c = 0.
  - If latched row_w = 0 or col_x = 0 -> FIN. Otherwise -> LOAD.
  - busy = 1 from E0.
  - A level-high unload_res with no rising edge never starts a stream (no restart while it stays high after finishing).
- LOAD:
  - At edge E1: data_out = snapshot[3r+c], data_valid = 1, then -> SEND.
  - First element is therefore visible 2 edges after the unload_res rise.
- SEND:
  - A transfer occurs at an edge where data_valid && data_ready.
  - While data_valid && !data_ready: data_out and data_valid are held stable. No bubbles, no drops.
  - On transfer, if c < col_x-1: c++.
  - Else if r < row_w-1: c = 0, r++.
  - Else (last element): -> FIN.
  - On a non-final transfer, the next element is loaded at that same edge and data_valid stays 1, so back-to-back ready gives one element per cycle.
  - On the final transfer, data_valid clears at that edge.
- FIN:
  - done = 1 for exactly one cycle, busy = 0 at the following edge, -> IDLE.
- Index arithmetic: index = 3*r + c, computed in 4 bits; never exceeds 8 for legal dims.
- Dims of 3 are the maximum. Latched values are only compared against counters; no wrap-around is possible.
- Sampling is fixed at the snapshot: mac_res, row_w and col_x changes after E0 do not affect the stream in progress.
- unload_res rising while busy is ignored, and the edge-detect register keeps tracking.
- clear_n asserted mid-stream aborts immediately:
  - data_valid drops asynchronously.
  - Nothing further is emitted and no done pulse is issued.
- data_ready is ignored when data_valid = 0.
- Total elements emitted = row_w * col_x.

Optional Feature:
- Macro RESULT_UNLOADER_LAST_EN.
- When defined:
  - Extra output data_last (1 bit), registered, reset 0.
  - data_last is high together with data_valid on the final element only, and clears with data_valid.
  - It is also high on the single element of a 1x1 result.
- When undefined:
  - Port data_last does not exist; consumers rely on done.
  - All other behaviour is identical.

Test Plan:
- 3x3 stream, ready tied 1:
  - Stimulus: row_w = 3, col_x = 3, mac_res slot k = 100 + k, unload_res rises.
  - Required: data_out 100..108 on 9 consecutive cycles starting 2 edges after the rise; done pulses once, the cycle after 108 transfers.
- 2x3 with back-pressure:
  - Stimulus: row_w = 2, col_x = 3, slots = k, ready low on alternating cycles.
  - Required: output 0, 1, 2, 3, 4, 5; each value held stable while ready = 0; no value skipped or repeated.
- Partial columns:
  - Stimulus: row_w = 3, col_x = 2.
  - Required: slots 0, 1, 3, 4, 6, 7 emitted (2, 5, 8 skipped); 6 transfers total.
- Zero dimension:
  - Stimulus: row_w = 0, col_x = 3, unload_res rises.
  - Required: data_valid never asserts; done pulses once; busy returns to 0.
- Mid-stream reset and restart:
  - Stimulus: 3x3 stream; clear_n low after the 4th transfer; release; then a new unload_res rise with slots = 675.
  - Required: data_valid drops immediately with no done pulse; the new stream emits 675 nine times; a level-held unload_res without a new rise produces no second stream.
- With RESULT_UNLOADER_LAST_EN defined:
  - Stimulus: 1x1 result, slot 0 = 675.
  - Required: data_out = 675, data_valid = 1 and data_last = 1 in the same cycle; both clear after the transfer.
